// File: rtl/ascon_seq_pkg.sv
// Shared definitions for the ASCON wave sequencer.
//   seq_state_t  : sequencer FSM states (IDLE, RUN, DONE)
//   WORD_W_DEF   : default data/cipher word width in bits
//   N_WORDS_DEF  : default maximum number of words per frame
//   word_lsb()   : bit offset of word k inside a packed frame, where
//                  word 0 occupies the most-significant WORD_W bits
package ascon_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int WORD_W_DEF  = 64;
    localparam int N_WORDS_DEF = 23;

    // Frames are packed with word 0 at the top, so word k starts
    // (N_WORDS-1-k) words above bit 0.
    function automatic int word_lsb(input int k, input int n_words, input int word_w);
        return (n_words - 1 - k) * word_w;
    endfunction

endpackage

// File: rtl/ascon_wave_sequencer_wave_collector.sv
// Index-addressed output register bank for the collected cipher frame.
//   clk, rst : clock and asynchronous active-high reset
//   clear    : zero the whole bank (takes priority over a write)
//   wr_en    : write wr_data into word wr_idx
//   wr_idx   : word index, 0 = most-significant word of wave_o
//   wr_data  : cipher word to store
//   wave_o   : the collected frame, same word ordering as the input frame
module wave_collector
    import ascon_seq_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEF,
    parameter int N_WORDS = N_WORDS_DEF,
    parameter int CNT_W   = $clog2(N_WORDS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      wr_en,
    input  logic [CNT_W-1:0]          wr_idx,
    input  logic [WORD_W-1:0]         wr_data,
    output logic [N_WORDS*WORD_W-1:0] wave_o
);

    // The bank is zeroed whenever a new frame is accepted so that words past
    // the active length stay 0; otherwise one word is written per strobe.
    // An index at or beyond N_WORDS matches no word and writes nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wave_o <= '0;
        end else if (clear) begin
            wave_o <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < N_WORDS; k++) begin
                if (wr_idx == CNT_W'(k)) begin
                    wave_o[word_lsb(k, N_WORDS, WORD_W) +: WORD_W] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/ascon_wave_sequencer.sv
// Frame sequencer between the UART front end and the ASCON cipher engine.
// Latches a frame of 1..N_WORDS words, streams it to the engine over a
// valid/ready handshake and gathers the returned cipher words into wave_o.
//   clock_i, reset_i   : clock and asynchronous active-high reset
//   start_i, nwords_i  : frame request and its word count (1..N_WORDS)
//   abort_i            : abandon the frame in flight
//   wave_i             : plaintext frame, word 0 in the top WORD_W bits
//   data_o, data_valid_o, data_ready_i, last_o : feed handshake to engine
//   cipher_i, cipher_valid_i                   : cipher words from engine
//   wave_o             : collected cipher frame
//   busy_o, done_o, err_o : status (RUN/DONE, completion pulse, sticky error)
module ascon_wave_sequencer
    import ascon_seq_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEF,
    parameter int N_WORDS = N_WORDS_DEF,
    parameter int CNT_W   = $clog2(N_WORDS + 1)
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [CNT_W-1:0]          nwords_i,
    input  logic [N_WORDS*WORD_W-1:0] wave_i,
    output logic [WORD_W-1:0]         data_o,
    output logic                      data_valid_o,
    input  logic                      data_ready_i,
    output logic                      last_o,
    input  logic [WORD_W-1:0]         cipher_i,
    input  logic                      cipher_valid_i,
    output logic [N_WORDS*WORD_W-1:0] wave_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);

    localparam int               FRAME_W = N_WORDS * WORD_W;
    localparam logic [CNT_W-1:0] N_MAX   = CNT_W'(N_WORDS);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    seq_state_t         state;
    seq_state_t         state_next;
    logic [FRAME_W-1:0] frame;
    logic [CNT_W-1:0]   n_words;
    logic [CNT_W-1:0]   feed_cnt;
    logic [CNT_W-1:0]   col_cnt;
    logic               err;

    logic start_ok;
    logic accept_start;
    logic bad_start;
    logic abort_hit;
    logic col_open;
    logic feed_fire;
    logic col_fire;
    logic col_err;
    logic col_last;

    // Event decode. Abort outranks everything else in RUN/DONE, so it
    // suppresses handshakes, collection writes and new error reports.
    // A cipher word is only legal in RUN while it has a fed word to match.
    always_comb begin
        start_ok     = start_i && (nwords_i != '0) && (nwords_i <= N_MAX);
        accept_start = (state == IDLE) && start_ok;
        bad_start    = (state == IDLE) && start_i && !start_ok;
        abort_hit    = abort_i && (state != IDLE);
        col_open     = (state == RUN) && (col_cnt < feed_cnt);
        feed_fire    = data_valid_o && data_ready_i && !abort_hit;
        col_fire     = cipher_valid_i && col_open && !abort_hit;
        col_err      = cipher_valid_i && !col_open && !abort_hit;
        col_last     = col_fire && ((col_cnt + ONE) == n_words);
    end

    // Status outputs are decoded from state so they drop the cycle after an
    // abort; done_o is additionally masked by abort arriving in DONE itself.
    always_comb begin
        data_valid_o = (state == RUN) && (feed_cnt < n_words);
        last_o       = data_valid_o && (feed_cnt == (n_words - ONE));
        busy_o       = (state == RUN) || (state == DONE);
        done_o       = (state == DONE) && !abort_i;
        err_o        = err;
    end

    // Word mux into the engine. Gated by data_valid_o so an idle feed
    // presents 0 rather than a stale frame word.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < N_WORDS; k++) begin
            if (data_valid_o && (feed_cnt == CNT_W'(k))) begin
                data_o = frame[word_lsb(k, N_WORDS, WORD_W) +: WORD_W];
            end
        end
    end

    // Next-state logic. RUN moves to DONE on the same edge that stores the
    // final cipher word, so DONE coincides with col_cnt == n_words.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort_hit) begin
                    state_next = IDLE;
                end else if (col_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame latch and the two counters. Every return to IDLE (normal finish
    // or abort) clears the counters; the latched frame is kept until the
    // next accepted start overwrites it.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            frame    <= '0;
            n_words  <= '0;
            feed_cnt <= '0;
            col_cnt  <= '0;
        end else if (accept_start) begin
            frame    <= wave_i;
            n_words  <= nwords_i;
            feed_cnt <= '0;
            col_cnt  <= '0;
        end else if (state_next == IDLE) begin
            feed_cnt <= '0;
            col_cnt  <= '0;
        end else begin
            if (feed_fire) begin
                feed_cnt <= feed_cnt + ONE;
            end
            if (col_fire) begin
                col_cnt <= col_cnt + ONE;
            end
        end
    end

    // Sticky protocol error. A new report wins over the clear from an
    // accepted start in the same cycle so that no violation is lost.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            err <= 1'b0;
        end else if (col_err || bad_start) begin
            err <= 1'b1;
        end else if (accept_start) begin
            err <= 1'b0;
        end
    end

    wave_collector #(
        .WORD_W  (WORD_W),
        .N_WORDS (N_WORDS),
        .CNT_W   (CNT_W)
    ) u_collector (
        .clk     (clock_i),
        .rst     (reset_i),
        .clear   (accept_start),
        .wr_en   (col_fire),
        .wr_idx  (col_cnt),
        .wr_data (cipher_i),
        .wave_o  (wave_o)
    );

endmodule

// File: tb/tb_ascon_wave_sequencer.sv
// Self-checking bench for ascon_wave_sequencer: a table of start requests,
// then whole frames driven against a transaction-level engine model that
// records fed words in order and returns their complement two cycles later.
module tb_ascon_wave_sequencer;

    localparam int WORD_W  = 64;
    localparam int N_WORDS = 23;
    localparam int CNT_W   = $clog2(N_WORDS + 1);
    localparam int FRAME_W = N_WORDS * WORD_W;
    localparam logic [WORD_W-1:0] ONES = '1;

    logic               clock_i = 1'b0;
    logic               reset_i;
    logic               start_i;
    logic               abort_i;
    logic [CNT_W-1:0]   nwords_i;
    logic [FRAME_W-1:0] wave_i;
    logic [WORD_W-1:0]  data_o;
    logic               data_valid_o;
    logic               data_ready_i;
    logic               last_o;
    logic [WORD_W-1:0]  cipher_i;
    logic               cipher_valid_i;
    logic [FRAME_W-1:0] wave_o;
    logic               busy_o;
    logic               done_o;
    logic               err_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string name;
        int    nw;
        logic  expErr;
        logic  expBusy;
    } startVec_t;

    ascon_wave_sequencer #(
        .WORD_W  (WORD_W),
        .N_WORDS (N_WORDS),
        .CNT_W   (CNT_W)
    ) dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .nwords_i       (nwords_i),
        .wave_i         (wave_i),
        .data_o         (data_o),
        .data_valid_o   (data_valid_o),
        .data_ready_i   (data_ready_i),
        .last_o         (last_o),
        .cipher_i       (cipher_i),
        .cipher_valid_i (cipher_valid_i),
        .wave_o         (wave_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    always #5 clock_i = ~clock_i;

    function automatic logic [WORD_W-1:0] getWord(input logic [FRAME_W-1:0] f, input int k);
        return f[(N_WORDS - 1 - k) * WORD_W +: WORD_W];
    endfunction

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic a, input int n, input logic r,
                                 input logic cv, input logic [WORD_W-1:0] cd);
        logic [31:0] nv;
        nv             = n;
        start_i        = s;
        abort_i        = a;
        nwords_i       = nv[CNT_W-1:0];
        data_ready_i   = r;
        cipher_valid_i = cv;
        cipher_i       = cd;
    endtask

    task automatic checkOutput(input string name, input logic [WORD_W-1:0] actual,
                               input logic [WORD_W-1:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic checkWave(input string name, input logic [FRAME_W-1:0] expected);
        for (int k = 0; k < N_WORDS; k++) begin
            checkOutput($sformatf("%s_wave%0d", name, k), getWord(wave_o, k), getWord(expected, k));
        end
    endtask

    task automatic randomFrame(output logic [FRAME_W-1:0] f);
        for (int k = 0; k < N_WORDS; k++) begin
            f[(N_WORDS - 1 - k) * WORD_W +: WORD_W] = {$urandom, $urandom};
        end
    endtask

    // Runs one frame from IDLE. The engine model accepts words with
    // probability readyPct and returns each word's complement two cycles
    // after the accepting edge. abortAfter >= 0 aborts once that many cipher
    // words are stored; earlyCipher sends a stray cipher word before any
    // word has been fed; startHold keeps start_i high into RUN.
    task automatic runFrame(input string tag, input int n, input logic [FRAME_W-1:0] frame,
                            input int readyPct, input int abortAfter, input bit earlyCipher,
                            input int startHold);
        logic [WORD_W-1:0]  pendData[$];
        int                 pendDue[$];
        logic [FRAME_W-1:0] expWave;
        logic [WORD_W-1:0]  prevData;
        logic [WORD_W-1:0]  cw;
        bit                 prevStall;
        bit                 aborting;
        bit                 finished;
        logic               rdy;
        int                 fed;
        int                 got;

        expWave   = '0;
        prevData  = '0;
        prevStall = 0;
        aborting  = 0;
        finished  = 0;
        fed       = 0;
        got       = 0;
        wave_i    = frame;
        applyStimulus(1, 0, n, 0, 0, '0);
        step();
        checkOutput({tag, "_busy_after_start"}, 64'(busy_o), 64'd1);
        checkOutput({tag, "_err_after_start"}, 64'(err_o), 64'd0);

        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            start_i = (cyc < startHold);
            if (aborting) begin
                checkOutput({tag, "_busy_after_abort"}, 64'(busy_o), 64'd0);
                checkOutput({tag, "_valid_after_abort"}, 64'(data_valid_o), 64'd0);
                checkOutput({tag, "_done_after_abort"}, 64'(done_o), 64'd0);
                finished = 1;
            end else if (done_o) begin
                checkOutput({tag, "_fed_at_done"}, 64'(fed), 64'(n));
                checkOutput({tag, "_got_at_done"}, 64'(got), 64'(n));
                applyStimulus(0, 0, 0, 0, 0, '0);
                step();
                checkOutput({tag, "_busy_after_done"}, 64'(busy_o), 64'd0);
                checkOutput({tag, "_done_width"}, 64'(done_o), 64'd0);
                finished = 1;
            end else begin
                if (prevStall) begin
                    checkOutput({tag, "_valid_held"}, 64'(data_valid_o), 64'd1);
                    checkOutput({tag, "_data_held"}, data_o, prevData);
                end
                if (data_valid_o) begin
                    checkOutput($sformatf("%s_data%0d", tag, fed), data_o, getWord(frame, fed));
                    checkOutput($sformatf("%s_last%0d", tag, fed), 64'(last_o), 64'(fed == n - 1));
                end else begin
                    checkOutput({tag, "_last_idle"}, 64'(last_o), 64'd0);
                end
                if (abortAfter >= 0 && got == abortAfter) begin
                    applyStimulus(startHold > cyc, 1, n, 0, 0, '0);
                    aborting = 1;
                end else begin
                    rdy = (earlyCipher && cyc == 0) ? 1'b0 : ($urandom_range(99) < readyPct);
                    data_ready_i = rdy;
                    prevStall    = data_valid_o && !rdy;
                    prevData     = data_o;
                    if (data_valid_o && rdy) begin
                        pendData.push_back(getWord(frame, fed) ^ ONES);
                        pendDue.push_back(cyc + 2);
                        fed++;
                    end
                    cipher_valid_i = 1'b0;
                    cipher_i       = '0;
                    if (earlyCipher && cyc == 0) begin
                        cipher_valid_i = 1'b1;
                        cipher_i       = 64'hDEAD_BEEF_0BAD_F00D;
                    end else if (pendDue.size() > 0 && pendDue[0] <= cyc) begin
                        cw = pendData.pop_front();
                        void'(pendDue.pop_front());
                        cipher_valid_i = 1'b1;
                        cipher_i       = cw;
                        expWave[(N_WORDS - 1 - got) * WORD_W +: WORD_W] = cw;
                        got++;
                    end
                end
                step();
            end
        end
        checkOutput({tag, "_finished"}, 64'(finished), 64'd1);
        applyStimulus(0, 0, 0, 0, 0, '0);
        checkWave(tag, expWave);
        checkOutput({tag, "_err_end"}, 64'(err_o), 64'(earlyCipher));
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput({tag, "_no_extra_done"}, 64'(done_o), 64'd0);
            checkOutput({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
        end
    endtask

    initial begin
        startVec_t          vecs[5];
        logic [FRAME_W-1:0] frame;
        logic [FRAME_W-1:0] zeroFrame;
        int                 n;

        vecs[0] = '{"nw0",  0,  1'b1, 1'b0};
        vecs[1] = '{"nw24", 24, 1'b1, 1'b0};
        vecs[2] = '{"nw31", 31, 1'b1, 1'b0};
        vecs[3] = '{"nw1",  1,  1'b0, 1'b1};
        vecs[4] = '{"nw23", 23, 1'b0, 1'b1};
        zeroFrame = '0;

        reset_i = 1'b1;
        wave_i  = '0;
        applyStimulus(0, 0, 0, 0, 0, '0);
        repeat (3) @(posedge clock_i);
        #1;
        checkOutput("reset_busy", 64'(busy_o), 64'd0);
        checkOutput("reset_valid", 64'(data_valid_o), 64'd0);
        checkOutput("reset_done", 64'(done_o), 64'd0);
        checkOutput("reset_err", 64'(err_o), 64'd0);
        checkOutput("reset_data", data_o, 64'd0);
        checkWave("reset", zeroFrame);
        @(negedge clock_i);
        reset_i = 1'b0;
        step();

        // Start requests from IDLE: bad counts raise err and stay idle,
        // good ones enter RUN and clear err; each good one is then aborted.
        wave_i = '1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, vecs[i].nw, 0, 0, '0);
            step();
            applyStimulus(0, 0, 0, 0, 0, '0);
            checkOutput({vecs[i].name, "_err"}, 64'(err_o), 64'(vecs[i].expErr));
            checkOutput({vecs[i].name, "_busy"}, 64'(busy_o), 64'(vecs[i].expBusy));
            checkOutput({vecs[i].name, "_valid"}, 64'(data_valid_o), 64'(vecs[i].expBusy));
            if (busy_o) begin
                abort_i = 1'b1;
                step();
                abort_i = 1'b0;
                checkOutput({vecs[i].name, "_abort_idle"}, 64'(busy_o), 64'd0);
            end
        end

        // Full-length frame, word k = k, engine always ready.
        for (int k = 0; k < N_WORDS; k++) begin
            frame[(N_WORDS - 1 - k) * WORD_W +: WORD_W] = 64'(k);
        end
        runFrame("full", N_WORDS, frame, 100, -1, 0, 0);

        // Short frame under random backpressure.
        randomFrame(frame);
        runFrame("short3", 3, frame, 50, -1, 0, 0);

        // Stray cipher word before anything is fed.
        randomFrame(frame);
        runFrame("early", 5, frame, 80, -1, 1, 0);

        // Abort after four stored cipher words, then a clean frame.
        randomFrame(frame);
        runFrame("abort", 10, frame, 70, 4, 0, 0);
        randomFrame(frame);
        runFrame("after_abort", 6, frame, 100, -1, 0, 0);

        // start_i held into RUN must not restart the frame.
        randomFrame(frame);
        runFrame("hold", 5, frame, 100, -1, 0, 3);

        for (int i = 0; i < 4; i++) begin
            n = $urandom_range(N_WORDS, 1);
            randomFrame(frame);
            runFrame($sformatf("rand%0d", i), n, frame, 60, -1, 0, 0);
        end

        // Asynchronous reset in the middle of a frame, with start_i held.
        randomFrame(frame);
        wave_i = frame;
        applyStimulus(1, 0, 10, 1, 0, '0);
        step();
        step();
        applyStimulus(1, 0, 10, 1, 1, 64'h0123_4567_89AB_CDEF);
        step();
        applyStimulus(1, 0, 10, 1, 0, '0);
        checkOutput("midrun_busy", 64'(busy_o), 64'd1);
        checkOutput("midrun_word0", getWord(wave_o, 0), 64'h0123_4567_89AB_CDEF);
        #2;
        reset_i = 1'b1;
        #1;
        checkOutput("areset_busy", 64'(busy_o), 64'd0);
        checkOutput("areset_valid", 64'(data_valid_o), 64'd0);
        checkOutput("areset_last", 64'(last_o), 64'd0);
        checkOutput("areset_done", 64'(done_o), 64'd0);
        checkOutput("areset_err", 64'(err_o), 64'd0);
        checkOutput("areset_data", data_o, 64'd0);
        checkWave("areset", zeroFrame);
        start_i = 1'b0;
        @(negedge clock_i);
        reset_i = 1'b0;
        step();
        checkOutput("post_reset_busy", 64'(busy_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
